// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract sequenced through one external
// 4-bit adder slice, one nibble per cycle, LSB nibble first.
module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [NIB-1:0][3:0]   a_reg;
    logic [NIB-1:0][3:0]   b_reg;
    logic [NIB-1:0][3:0]   sum_reg;
    logic [NIB-1:0][3:0]   sum_next;
    logic                  carry_reg;
    logic [IDXW-1:0]       idx;
    logic                  ovf_next;

    assign in_ready = (state == IDLE);

    // Present the current nibble pair to the shared slice only while running.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry_reg;
        end
    end

    // Partial result with the slice output merged into the current nibble.
    always_comb begin
        sum_next      = sum_reg;
        sum_next[idx] = add_sum;
    end

    // Signed overflow: like-signed operands producing a differently-signed MSB.
    always_comb begin
        ovf_next = (a_reg[NIB-1][3] == b_reg[NIB-1][3]) && (add_sum[3] != a_reg[NIB-1][3]);
    end

    // Sequencer: accept operands, walk nibbles, hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_sub ? ~in_b : in_b;
                        carry_reg <= in_sub ? 1'b1 : in_cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= add_cout;
                    idx       <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        out_sum   <= sum_next;
                        out_cout  <= add_cout;
                        out_ovf   <= ovf_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl: WIDTH 4/16/32 instances, each with a
// behavioural 4-bit adder slice, checked through a result scoreboard.
module tb_nibble_serial_add_ctrl;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    res_t sbq[$];
    res_t mon_e;

    // index 0: WIDTH=4, 1: WIDTH=16, 2: WIDTH=32
    logic        vin[3], rdy[3], cin[3], sub[3], ordy[3];
    logic        ov[3], co[3], of[3], bsy[3], ac[3], acout[3];
    logic [31:0] ta[3], tb[3], so[3];
    logic [3:0]  aa[3], ab[3], as[3];
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;

    logic [31:0] bva[3][3], bvb[3][3];
    logic        bc[3][3], bs[3][3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign so[0] = 32'(s4);
    assign so[1] = 32'(s16);
    assign so[2] = s32;

    // Behavioural 4-bit adder slices
    for (genvar k = 0; k < 3; k++) begin : g_add
        assign {acout[k], as[k]} = 5'(aa[k]) + 5'(ab[k]) + 5'(ac[k]);
    end

    nibble_serial_add_ctrl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
        .in_a(ta[0][3:0]), .in_b(tb[0][3:0]), .in_cin(cin[0]), .in_sub(sub[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s4), .out_cout(co[0]),
        .out_ovf(of[0]), .busy(bsy[0]), .add_a(aa[0]), .add_b(ab[0]),
        .add_cin(ac[0]), .add_sum(as[0]), .add_cout(acout[0]));

    nibble_serial_add_ctrl #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
        .in_a(ta[1][15:0]), .in_b(tb[1][15:0]), .in_cin(cin[1]), .in_sub(sub[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s16), .out_cout(co[1]),
        .out_ovf(of[1]), .busy(bsy[1]), .add_a(aa[1]), .add_b(ab[1]),
        .add_cin(ac[1]), .add_sum(as[1]), .add_cout(acout[1]));

    nibble_serial_add_ctrl #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(rdy[2]),
        .in_a(ta[2]), .in_b(tb[2]), .in_cin(cin[2]), .in_sub(sub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s32), .out_cout(co[2]),
        .out_ovf(of[2]), .busy(bsy[2]), .add_a(aa[2]), .add_b(ab[2]),
        .add_cin(ac[2]), .add_sum(as[2]), .add_cout(acout[2]));

    function automatic int wid(int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 32;
    endfunction

    function automatic res_t mk(logic o, logic c, logic [31:0] s);
        res_t r;
        r.ovf  = o;
        r.cout = c;
        r.sum  = s;
        return r;
    endfunction

    // Whole-word reference for add/subtract at width w
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic c, logic s);
        logic [63:0] m, aw, bw, t;
        res_t r;
        m  = (64'd1 << w) - 64'd1;
        aw = {32'd0, a} & m;
        bw = s ? (~{32'd0, b}) & m : {32'd0, b} & m;
        t  = aw + bw + 64'(s ? 1'b1 : c);
        r.sum  = 32'(t & m);
        r.cout = t[w];
        r.ovf  = (aw[w-1] == bw[w-1]) && (t[w-1] != aw[w-1]);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; returns at #1 after the accepting edge
    task automatic send(int k, logic [31:0] a, logic [31:0] b, logic c, logic s,
                        res_t ex, logic push, logic hold, output int tacc);
        ta[k] = a; tb[k] = b; cin[k] = c; sub[k] = s; vin[k] = 1'b1;
        if (push) sbq.push_back(ex);
        tacc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy[k]) begin
                @(posedge clk);
                #1;
                tacc = cyc;
                break;
            end
        end
        if (tacc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d", k);
        end
        if (!hold) vin[k] = 1'b0;
    endtask

    // Count edges until out_valid, recording adder drive while busy
    task automatic wait_valid(int k, output int n, output logic [31:0] sa, output logic [7:0] sc);
        n = 0; sa = '0; sc = '0;
        while (!ov[k] && n < 100) begin
            if (bsy[k]) begin
                sa = {sa[27:0], aa[k]};
                sc = {sc[6:0], ac[k]};
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov[k]) begin
            checks++; errors++;
            $display("FAIL valid_timeout dut%0d", k);
        end
    endtask

    task automatic idle_wait(int k);
        int n;
        n = 0;
        while (!(rdy[k] && sbq.size() == 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(rdy[k] && sbq.size() == 0)) begin
            checks++; errors++;
            $display("FAIL idle_timeout dut%0d pending=%0d", k, sbq.size());
        end
    endtask

    // Scoreboard monitor: compare on each result handshake
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && ov[k] && ordy[k]) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result dut%0d got %0h expected none", k, so[k]);
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("sum_w%0d", wid(k)), 64'(so[k]), 64'(mon_e.sum));
                    chk($sformatf("cout_w%0d", wid(k)), 64'(co[k]), 64'(mon_e.cout));
                    chk($sformatf("ovf_w%0d", wid(k)), 64'(of[k]), 64'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, tacc, tprev, k;
        logic [31:0] sa;
        logic [7:0]  sc;
        res_t        ex;

        bva = '{'{32'h9, 32'h3, 32'h2}, '{32'hA5A5, 32'h1000, 32'hFFFF},
                '{32'hDEADBEEF, 32'h80000000, 32'h7FFFFFFF}};
        bvb = '{'{32'h8, 32'h5, 32'h7}, '{32'h5A5A, 32'h2000, 32'h0001},
                '{32'h12345678, 32'h00000001, 32'h7FFFFFFF}};
        bc  = '{'{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1}};
        bs  = '{'{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; ordy[i] = 1'b1; ta[i] = '0; tb[i] = '0;
            cin[i] = 1'b0; sub[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(rdy[i]), 64'd1);
            chk("rst_out_valid", 64'(ov[i]), 64'd0);
            chk("rst_busy", 64'(bsy[i]), 64'd0);
            chk("rst_out_sum", 64'(so[i]), 64'd0);
            chk("rst_add_drive", 64'({aa[i], ab[i], ac[i]}), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add, latency and nibble order
        send(1, 32'h1234, 32'h0FEF, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h2223), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        chk("latency_w16", 64'(n), 64'd4);
        chk("add_a_seq", 64'(sa[15:0]), 64'h4321);
        chk("add_cin_seq", 64'(sc[3:0]), 64'b0111);
        idle_wait(1);

        // Carry ripple through every nibble
        send(1, 32'hFFFF, 32'h0000, 1'b1, 1'b0, mk(1'b0, 1'b1, 32'h0000), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        chk("ripple_cin_seq", 64'(sc[3:0]), 64'b1111);
        idle_wait(1);

        // Signed overflow on add
        send(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h8000), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        idle_wait(1);

        // Subtract with borrow, and subtract ignoring cin with overflow
        send(1, 32'h0005, 32'h0007, 1'b0, 1'b1, mk(1'b0, 1'b0, 32'hFFFE), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        idle_wait(1);
        send(1, 32'h8000, 32'h0001, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h7FFF), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        idle_wait(1);

        // Backpressure: result held, new requests refused
        ordy[1] = 1'b0;
        send(1, 32'h1111, 32'h2222, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h3333), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        for (int i = 0; i < 10; i++) begin
            ta[1] = 32'hAAA0 + 32'(i); tb[1] = 32'h0101; vin[1] = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(ov[1]), 64'd1);
            chk("bp_out_sum", 64'(so[1]), 64'h3333);
            chk("bp_flags", 64'({co[1], of[1]}), 64'd0);
            chk("bp_in_ready", 64'(rdy[1]), 64'd0);
            chk("bp_busy", 64'(bsy[1]), 64'd0);
        end
        vin[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(ov[1]), 64'd0);
        chk("bp_release_ready", 64'(rdy[1]), 64'd1);
        send(1, 32'hABCD, 32'h1111, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'hBCDE), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        idle_wait(1);

        // Reset while idx==1
        send(1, 32'h1234, 32'h1111, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0), 1'b0, 1'b0, tacc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 64'(rdy[1]), 64'd1);
        chk("mid_rst_busy", 64'(bsy[1]), 64'd0);
        chk("mid_rst_out_valid", 64'(ov[1]), 64'd0);
        chk("mid_rst_out_sum", 64'(so[1]), 64'd0);
        chk("mid_rst_add_drive", 64'({aa[1], ab[1], ac[1]}), 64'd0);
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ov[1]) n++;
        end
        chk("mid_rst_no_valid", 64'(n), 64'd0);
        send(1, 32'h4321, 32'h1234, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h5555), 1'b1, 1'b0, tacc);
        wait_valid(1, n, sa, sc);
        idle_wait(1);

        // Back-to-back with out_ready high: WIDTH 16, then 4, then 32
        for (int j = 0; j < 3; j++) begin
            k = (j == 0) ? 1 : (j == 1) ? 0 : 2;
            ordy[k] = 1'b1;
            tprev = 0;
            for (int i = 0; i < 3; i++) begin
                ex = model(wid(k), bva[k][i], bvb[k][i], bc[k][i], bs[k][i]);
                send(k, bva[k][i], bvb[k][i], bc[k][i], bs[k][i], ex, 1'b1, 1'b1, tacc);
                if (i > 0) chk($sformatf("b2b_gap_w%0d", wid(k)), 64'(tacc - tprev), 64'(wid(k) / 4 + 2));
                tprev = tacc;
            end
            vin[k] = 1'b0;
            idle_wait(k);
        end

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
